// File: rtl/dm_pkg.sv
// Shared types for the data-memory responder: FSM states, bus widths, latched request.
// Optional feature macro: DM_ALIGN_CHECK_EN (misaligned-access fault).
package dm_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [BE_W-1:0]   be;
      logic [WORD_W-1:0] wdata;
   } dm_req_t;

   function automatic logic [WORD_W-1:0] be_merge(
      input logic [WORD_W-1:0] old_w,
      input logic [WORD_W-1:0] new_w,
      input logic [BE_W-1:0]   be
   );
      logic [WORD_W-1:0] r;
      r = old_w;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dm_ram.sv
// Word storage with byte-enabled synchronous write and asynchronous read.
// Reset clears every word.
module dm_ram
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int AW = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [AW-1:0]     idx,
   input  logic [BE_W-1:0]   be,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr) begin
         mem[idx] <= be_merge(mem[idx], wdata, be);
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: req/ack slave with fixed wait states and fault detection.
// Define DM_ALIGN_CHECK_EN to fault on addr[1:0] != 0.
module dm_responder
   import dm_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t            state, state_nx;
   logic [3:0]        cnt;
   dm_req_t           rq;
   logic              accept;
   logic              oob;
   logic              misalign;
   logic              fault;
   logic              wr;
   logic [WORD_W-1:0] ram_rdata;

   assign accept = (state == IDLE) && req;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Request fields are frozen at acceptance; later input wiggles are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         rq  <= '0;
      end else if (accept) begin
         cnt <= WAIT_INIT;
         rq  <= '{we: we, addr: addr, be: be, wdata: wdata};
      end else if (state == WAIT) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (req) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
         WAIT: if (cnt <= 4'd1) state_nx = RESP;
         RESP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign oob = (rq.addr >> (AW + 2)) != 32'd0;

`ifdef DM_ALIGN_CHECK_EN
   assign misalign = |rq.addr[1:0];
`else
   logic unused_lsb;
   assign unused_lsb = ^rq.addr[1:0];
   assign misalign   = 1'b0;
`endif

   assign fault = oob || misalign;
   assign wr    = (state == RESP) && rq.we && !fault;

   dm_ram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .wr   (wr),
      .idx  (rq.addr[AW+1:2]),
      .be   (rq.be),
      .wdata(rq.wdata),
      .rdata(ram_rdata)
   );

   always_comb begin
      ready = 1'b0;
      ack   = 1'b0;
      rdata = '0;
      err   = 1'b0;
      unique case (1'b1)
         state == IDLE: ready = 1'b1;
         state == RESP: begin
            ack = 1'b1;
            err = fault;
            if (!fault && !rq.we) rdata = ram_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance for access
// checks and a WAIT_CYCLES=0 instance for back-to-back streaming.
module tb_dm_responder;

   logic        clk;
   logic        reset;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;
   logic        ready, ack, err;
   logic [31:0] rdata;

   logic        req0, we0;
   logic [31:0] addr0, wdata0;
   logic [3:0]  be0;
   logic        ready0, ack0, err0;
   logic [31:0] rdata0;

   int n_cmp = 0;
   int n_bad = 0;

   dm_responder #(
      .WAIT_CYCLES(2),
      .DEPTH_WORDS(1024)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .we   (we),
      .addr (addr),
      .be   (be),
      .wdata(wdata),
      .ready(ready),
      .ack  (ack),
      .rdata(rdata),
      .err  (err)
   );

   dm_responder #(
      .WAIT_CYCLES(0),
      .DEPTH_WORDS(1024)
   ) dut0 (
      .clk  (clk),
      .reset(reset),
      .req  (req0),
      .we   (we0),
      .addr (addr0),
      .be   (be0),
      .wdata(wdata0),
      .ready(ready0),
      .ack  (ack0),
      .rdata(rdata0),
      .err  (err0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One access on dut; inputs are scrambled after acceptance, req stays
   // high until ack is seen.
   task automatic access(input string tag, input logic w,
                         input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, input logic [31:0] exp_rd,
                         input logic exp_err);
      int   lat;
      logic quiet;
      lat   = 0;
      quiet = 1'b1;
      @(posedge clk);
      #1;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      @(negedge clk);
      check({tag, "_ready"}, ready, 1);
      @(posedge clk);
      #1;
      we = ~w; addr = ~a; be = ~b; wdata = ~d;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ack) begin
            lat = i;
            break;
         end
         if (ready || err || rdata != 32'd0) quiet = 1'b0;
      end
      check({tag, "_lat"}, lat, 3);
      check({tag, "_rdata"}, rdata, exp_rd);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_quiet"}, quiet, 1);
      req = 1'b0;
   endtask

   initial begin
      logic [5:0] ackv, rdyv;
      logic       q0;
      reset = 1'b1;
      req = 0; we = 0; addr = 0; be = 0; wdata = 0;
      req0 = 0; we0 = 0; addr0 = 0; be0 = 0; wdata0 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 0);
      check("rst_err", err, 0);
      check("rst_ready0", ready0, 1);

      // WAIT_CYCLES=0 with req held high: IDLE/RESP alternate.
      @(posedge clk);
      #1;
      req0 = 1'b1; addr0 = 32'h10;
      q0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ackv[i] = ack0;
         rdyv[i] = ready0;
         if (ack0 && (rdata0 != 32'd0 || err0)) q0 = 1'b0;
      end
      req0 = 1'b0;
      check("w0_ack", ackv, 6'b101010);
      check("w0_ready", rdyv, 6'b010101);
      check("w0_data", q0, 1);

      access("ld_init", 0, 32'h10, 4'h0, 0, 32'h0, 0);
      access("st_full", 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 0);
      access("ld_full", 0, 32'h10, 4'h0, 0, 32'hDEADBEEF, 0);
      access("st_part", 1, 32'h10, 4'h3, 32'h12345678, 32'h0, 0);
      access("ld_part", 0, 32'h10, 4'h0, 0, 32'hDEAD5678, 0);
      access("ld_oob", 0, 32'h1000, 4'h0, 0, 32'h0, 1);
      access("st_oob", 1, 32'h1000, 4'hF, 32'hCAFEF00D, 32'h0, 1);
      access("ld_w0", 0, 32'h0, 4'h0, 0, 32'h0, 0);
      access("st_last", 1, 32'hFFC, 4'hF, 32'hAABBCCDD, 32'h0, 0);
      access("ld_last", 0, 32'hFFC, 4'h0, 0, 32'hAABBCCDD, 0);
      access("st_al", 1, 32'h10, 4'hF, 32'h01020304, 32'h0, 0);
`ifdef DM_ALIGN_CHECK_EN
      access("ld_mis", 0, 32'h12, 4'h0, 0, 32'h0, 1);
`else
      access("ld_mis", 0, 32'h12, 4'h0, 0, 32'h01020304, 0);
`endif
      access("st_24", 1, 32'h24, 4'hF, 32'h00000077, 32'h0, 0);

      // Reset lands during the first WAIT cycle of a store to 0x20.
      @(posedge clk);
      #1;
      req = 1'b1; we = 1'b1; addr = 32'h20; be = 4'hF;
      wdata = 32'h55AA55AA;
      @(negedge clk);
      check("rmo_ready", ready, 1);
      @(negedge clk);
      check("rmo_wait", ready, 0);
      reset = 1'b1;
      req   = 1'b0;
      @(negedge clk);
      check("rmo_ready_after", ready, 1);
      check("rmo_ack_after", ack, 0);
      reset = 1'b0;
      q0 = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (ack || !ready) q0 = 1'b0;
      end
      check("rmo_no_ack", q0, 1);

      access("ld_20", 0, 32'h20, 4'h0, 0, 32'h0, 0);
      access("ld_24", 0, 32'h24, 4'h0, 0, 32'h0, 0);
      access("ld_10", 0, 32'h10, 4'h0, 0, 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
